// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core issue stage: condition codes,
// memory-op encoding, PC register index and the shadow-pipeline slot record.
package core_pkg;

    typedef enum logic [1:0] {
        CC_AL = 2'b00,
        CC_S  = 2'b01,
        CC_EQ = 2'b10,
        CC_NE = 2'b11
    } cc_e;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_LD   = 2'b01,
        MEM_ST   = 2'b10,
        MEM_ILL  = 2'b11   // decoded as no memory access
    } mem_e;

    localparam logic [3:0] PC_REG = 4'd15;

    // One in-flight instruction's side effects
    typedef struct packed {
        logic       v;
        logic [3:0] dest;
        logic       wr;
        logic       setz;
        logic       ld;
        logic       st;
        logic       jmp;
    } slot_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_JWAIT = 1'b1
    } state_e;

endpackage

// File: rtl/sb_hazard_cmp.sv
// Compares one fetched request against one shadow-pipeline slot.
// Purely combinational; the top ORs one instance per slot.
module sb_hazard_cmp (
    input  logic       req_src_en,
    input  logic [3:0] req_src,
    input  logic [3:0] req_dest,
    input  logic       req_flag,   // request reads or writes Z
    input  logic       req_ld,
    input  logic       req_st,
    input  logic       slot_v,
    input  logic [3:0] slot_dest,
    input  logic       slot_wr,
    input  logic       slot_setz,
    input  logic       slot_ld,
    input  logic       slot_st,
    output logic       hazard
);

    logic raw_src, raw_dest, flag_hz, mem_hz;

    // Dest is always read as op1, so a pending write to it is a hazard
    // whether or not the request itself writes.
    always_comb begin
        raw_src  = req_src_en && slot_wr && (slot_dest == req_src);
        raw_dest = slot_wr && (slot_dest == req_dest);
        flag_hz  = req_flag && slot_setz;
        mem_hz   = (req_ld && slot_st) || (req_st && slot_ld);
        hazard   = slot_v && (raw_src || raw_dest || flag_hz || mem_hz);
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage interlock: shadow pipeline of in-flight side effects, hazard
// detection and jump wait sequencing between fetch and decode.
// Optional feature macro: ISSUE_STALL_CNT_EN (saturating stall counter).
module issue_scoreboard
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREG  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_dest,
    input  logic [3:0]      req_src,
    input  logic            req_src_en,
    input  logic            req_wr,
    input  logic            req_setz,
    input  logic            req_usez,
    input  logic [1:0]      req_mem,
    output logic            issue_valid,
    output logic            bubble,
    output logic            redirect,
    output logic            wb_valid,
    output logic [3:0]      wb_dest,
    output logic [NREG-1:0] busy_mask,
    output logic [15:0]     stall_cnt
);

    slot_t [DEPTH-1:0] slot_q, slot_d;
    state_e            state_q, state_d;
    logic              issue_valid_q, issue_valid_d;
    logic              bubble_q, bubble_d;
    logic              redirect_q, redirect_d;
    logic [DEPTH-1:0]  hz;
    slot_t             req_slot;
    logic              fire;

    // Decode the request into slot form; illegal mem op decodes as none
    always_comb begin
        req_slot      = '0;
        req_slot.v    = 1'b1;
        req_slot.dest = req_dest;
        req_slot.wr   = req_wr;
        req_slot.setz = req_setz;
        req_slot.ld   = (req_mem == MEM_LD);
        req_slot.st   = (req_mem == MEM_ST);
        req_slot.jmp  = req_wr && (req_dest == PC_REG);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        sb_hazard_cmp u_cmp (
            .req_src_en (req_src_en),
            .req_src    (req_src),
            .req_dest   (req_dest),
            .req_flag   (req_usez || req_setz),
            .req_ld     (req_slot.ld),
            .req_st     (req_slot.st),
            .slot_v     (slot_q[g].v),
            .slot_dest  (slot_q[g].dest),
            .slot_wr    (slot_q[g].wr),
            .slot_setz  (slot_q[g].setz),
            .slot_ld    (slot_q[g].ld),
            .slot_st    (slot_q[g].st),
            .hazard     (hz[g])
        );
    end

    // FSM next state and ready: JWAIT holds issue until the jump reaches the last slot
    always_comb begin
        state_d    = state_q;
        redirect_d = 1'b0;
        req_ready  = 1'b0;
        case (state_q)
            ST_RUN: begin
                req_ready = ~|hz;
                if (req_valid && req_ready && req_slot.jmp)
                    state_d = ST_JWAIT;
            end
            ST_JWAIT: begin
                if (slot_q[DEPTH-1].v && slot_q[DEPTH-1].jmp) begin
                    state_d    = ST_RUN;
                    redirect_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign fire = req_valid && req_ready;

    // Shadow pipeline shift: slot 0 takes the request on fire, else a bubble
    always_comb begin
        slot_d[0]     = fire ? req_slot : '0;
        for (int i = 1; i < DEPTH; i++)
            slot_d[i] = slot_q[i-1];
        issue_valid_d = fire;
        bubble_d      = !fire;
    end

    // Pipeline, FSM and stage-2 status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q        <= '0;
            state_q       <= ST_RUN;
            issue_valid_q <= 1'b0;
            bubble_q      <= 1'b0;
            redirect_q    <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            bubble_q      <= bubble_d;
            redirect_q    <= redirect_d;
        end
    end

    // Pending-writer mask and writeback view of the last slot
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_q[i].v && slot_q[i].wr)
                busy_mask[slot_q[i].dest] = 1'b1;
        wb_valid = slot_q[DEPTH-1].v && slot_q[DEPTH-1].wr;
        wb_dest  = wb_valid ? slot_q[DEPTH-1].dest : 4'd0;
    end

    assign issue_valid = issue_valid_q;
    assign bubble      = bubble_q;
    assign redirect    = redirect_q;

`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a valid request is held back; saturate at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (req_valid && !req_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: table rows drive one request per cycle with the
// expected ready; expected issue/bubble are queued and checked next cycle.
module tb_issue_scoreboard;

    localparam int DEPTH = 4;
    localparam int NREG  = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [3:0]      req_dest = '0;
    logic [3:0]      req_src = '0;
    logic            req_src_en = 1'b0;
    logic            req_wr = 1'b0;
    logic            req_setz = 1'b0;
    logic            req_usez = 1'b0;
    logic [1:0]      req_mem = '0;
    logic            issue_valid, bubble, redirect, wb_valid;
    logic [3:0]      wb_dest;
    logic [NREG-1:0] busy_mask;
    logic [15:0]     stall_cnt;

    always #5 clk = ~clk;

    issue_scoreboard #(.DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_src(req_src), .req_src_en(req_src_en),
        .req_wr(req_wr), .req_setz(req_setz), .req_usez(req_usez), .req_mem(req_mem),
        .issue_valid(issue_valid), .bubble(bubble), .redirect(redirect),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .busy_mask(busy_mask),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        string      name;
        logic       valid;
        logic [3:0] dest;
        logic [3:0] src;
        logic       src_en;
        logic       wr;
        logic       setz;
        logic       usez;
        logic [1:0] mem;
        logic       exp_ready;
    } vec_t;

    vec_t tbl[$];
    bit   exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_exp = 0;

    function automatic vec_t mk(input string nm, input logic v, input logic [3:0] d,
                                input logic [3:0] s, input logic se, input logic w,
                                input logic sz, input logic uz, input logic [1:0] m,
                                input logic rdy);
        vec_t r;
        r.name = nm; r.valid = v; r.dest = d; r.src = s; r.src_en = se; r.wr = w;
        r.setz = sz; r.usez = uz; r.mem = m; r.exp_ready = rdy;
        return r;
    endfunction

    function automatic vec_t idle(input string nm, input logic rdy);
        return mk(nm, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rdy);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge: drive, check, then advance to the next negedge
    task automatic apply(input vec_t v);
        bit e;
        req_valid = v.valid; req_dest = v.dest; req_src = v.src; req_src_en = v.src_en;
        req_wr = v.wr; req_setz = v.setz; req_usez = v.usez; req_mem = v.mem;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({v.name, " issue_valid"}, 32'(issue_valid), 32'(e));
            chk({v.name, " bubble"}, 32'(bubble), 32'(!e));
        end else begin
            chk({v.name, " post-reset issue_valid"}, 32'(issue_valid), 32'd0);
            chk({v.name, " post-reset bubble"}, 32'(bubble), 32'd0);
        end
        chk({v.name, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
        exp_q.push_back(v.valid && v.exp_ready);
        if (v.valid && !v.exp_ready) stall_exp++;
        @(negedge clk);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic drain(input string nm);
        repeat (DEPTH) apply(idle(nm, 1'b1));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " issue_valid"}, 32'(issue_valid), 32'd0);
        chk({nm, " bubble"}, 32'(bubble), 32'd0);
        chk({nm, " redirect"}, 32'(redirect), 32'd0);
        chk({nm, " wb_valid"}, 32'(wb_valid), 32'd0);
        chk({nm, " wb_dest"}, 32'(wb_dest), 32'd0);
        chk({nm, " busy_mask"}, 32'(busy_mask), 32'd0);
        chk({nm, " stall_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t jmp_v, oth_v, oth_go, wr_z, eq_v, eq_go;
        int   exp_stall;

        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Independent stream: never stalls
        for (int d = 1; d <= 4; d++)
            tbl.push_back(mk("indep", 1, 4'(d), 0, 0, 1, 0, 0, 2'd0, 1));
        run_tbl();
        drain("indep_drain");
        chk("indep stall_cnt", 32'(stall_cnt), 32'd0);

        // RAW on src: DEPTH stall cycles, issues on the next
        tbl.push_back(mk("raw_wr", 1, 4'd2, 0, 0, 1, 0, 0, 2'd0, 1));
        repeat (DEPTH) tbl.push_back(mk("raw_dep", 1, 4'd7, 4'd2, 1, 0, 0, 0, 2'd0, 0));
        tbl.push_back(mk("raw_go", 1, 4'd7, 4'd2, 1, 0, 0, 0, 2'd0, 1));
        run_tbl();
        drain("raw_drain");

        // WAW on dest
        tbl.push_back(mk("waw_wr", 1, 4'd12, 0, 0, 1, 0, 0, 2'd0, 1));
        repeat (DEPTH) tbl.push_back(mk("waw_dep", 1, 4'd12, 0, 0, 1, 0, 0, 2'd0, 0));
        tbl.push_back(mk("waw_go", 1, 4'd12, 0, 0, 1, 0, 0, 2'd0, 1));
        run_tbl();
        drain("waw_drain");

        // Store then load stalls; load after load does not
        tbl.push_back(mk("mem_st", 1, 4'd8, 0, 0, 0, 0, 0, 2'b10, 1));
        repeat (DEPTH) tbl.push_back(mk("mem_ld", 1, 4'd9, 0, 0, 1, 0, 0, 2'b01, 0));
        tbl.push_back(mk("mem_ld_go", 1, 4'd9, 0, 0, 1, 0, 0, 2'b01, 1));
        tbl.push_back(mk("mem_ldld", 1, 4'd10, 0, 0, 1, 0, 0, 2'b01, 1));
        run_tbl();
        drain("mem_drain");

        // Illegal mem op behind a store is not a memory access
        tbl.push_back(mk("ill_st", 1, 4'd8, 0, 0, 0, 0, 0, 2'b10, 1));
        tbl.push_back(mk("ill_op", 1, 4'd11, 0, 0, 1, 0, 0, 2'b11, 1));
        run_tbl();
        drain("ill_drain");

        // Flag hazard: S-setting add then EQ user
        wr_z  = mk("flag_wr", 1, 4'd3, 0, 0, 1, 1, 0, 2'd0, 1);
        eq_v  = mk("flag_eq", 1, 4'd5, 0, 0, 0, 0, 1, 2'd0, 0);
        eq_go = mk("flag_eq_go", 1, 4'd5, 0, 0, 0, 0, 1, 2'd0, 1);
        apply(wr_z);
        for (int k = 1; k <= DEPTH; k++) begin
            chk("flag busy_mask", 32'(busy_mask), 32'h0008);
            apply(eq_v);
        end
        chk("flag busy_mask clear", 32'(busy_mask), 32'h0000);
        apply(eq_go);
        drain("flag_drain");

        // Jump: ready low while it drains, redirect as it leaves
        jmp_v  = mk("jmp", 1, 4'd15, 0, 0, 1, 0, 0, 2'd0, 1);
        oth_v  = mk("jmp_wait", 1, 4'd1, 0, 0, 1, 0, 0, 2'd0, 0);
        oth_go = mk("jmp_go", 1, 4'd1, 0, 0, 1, 0, 0, 2'd0, 1);
        apply(jmp_v);
        for (int k = 1; k <= DEPTH; k++) begin
            chk("jmp busy15", 32'(busy_mask[15]), 32'd1);
            chk("jmp redirect early", 32'(redirect), 32'd0);
            if (k == DEPTH) begin
                chk("jmp wb_valid", 32'(wb_valid), 32'd1);
                chk("jmp wb_dest", 32'(wb_dest), 32'd15);
            end
            apply(oth_v);
        end
        chk("jmp redirect", 32'(redirect), 32'd1);
        chk("jmp busy15 clear", 32'(busy_mask[15]), 32'd0);
        apply(oth_go);
        chk("jmp redirect pulse end", 32'(redirect), 32'd0);
        apply(idle("jmp_idle", 1'b1));
        drain("jmp_drain");

`ifdef ISSUE_STALL_CNT_EN
        exp_stall = stall_exp;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt total", 32'(stall_cnt), 32'(exp_stall));

        // Asynchronous reset in the middle of a jump wait
        apply(mk("rst_jmp", 1, 4'd15, 0, 0, 1, 0, 0, 2'd0, 1));
        apply(idle("rst_wait", 1'b0));
        #2 reset = 1'b0;
        #1;
        chk_all_zero("midjump reset");
        exp_q.delete();
        stall_exp = 0;
        @(negedge clk);
        reset = 1'b1;
        apply(idle("rst_after", 1'b1));
        for (int k = 0; k < DEPTH + 2; k++) begin
            chk("rst no redirect", 32'(redirect), 32'd0);
            apply(idle("rst_run", 1'b1));
        end
        chk("rst stall_cnt", 32'(stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-stage interlock controller for the 16-bit pipelined core. It sits between instruction fetch (stage 1) and decode/register read (stage 2). It tracks every in-flight instruction's register, Z-flag, memory and PC side effects in a fixed-depth shadow pipeline, and decides each cycle whether the fetched instruction issues or a NOP bubble is inserted. It replaces ad-hoc freeze logic with one sequenced hazard/jump controller.

## Interface
Parameters:
- DEPTH, 4, cycles from issue to writeback (slots tracked); legal 2..8
- NREG, 16, architectural registers; register 15 is the PC

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted when 0)
- req_valid  in  1  fetched instruction present
- req_ready  out  1  instruction may issue this cycle (combinational)
- req_dest  in  4  Dest field; always read as op1
- req_src  in  4  Op2 register index
- req_src_en  in  1  Op2 is a register (isReg)
- req_wr  in  1  instruction writes Dest
- req_setz  in  1  CC == S
- req_usez  in  1  CC is EQ or NE
- req_mem  in  2  00 none, 01 load, 10 store, 11 illegal (treated as 00)
- issue_valid  out  1  registered: real instruction entered stage 2
- bubble  out  1  registered: NOP entered stage 2
- redirect  out  1  registered one-cycle pulse: jump retired, fetch may restart
- wb_valid  out  1  slot DEPTH-1 holds a real writing instruction
- wb_dest  out  4  its destination
- busy_mask  out  NREG  bit r set if any slot writes r
- stall_cnt  out  16  saturating stall-cycle counter

## Operation
- Shadow pipeline of DEPTH slots. Each slot holds {v, dest, wr, setz, ld, st, jmp}, with jmp = wr && dest==15. All slots shift by one every cycle. Slot 0 loads the request on fire (fire = req_valid && req_ready), otherwise it loads an empty bubble. The slot DEPTH-1 contents are discarded at the next edge.
- Hazards: every valid slot participates, including slot DEPTH-1.
  - RAW on src: req_src_en and a slot with wr and a matching dest.
  - RAW/WAW on dest: a slot with wr and dest == req_dest.
  - Flag: (req_usez or req_setz) and any slot with setz.
  - Memory: a load against any pending st, or a store against any pending ld.
- FSM states RUN and JWAIT.
  - RUN: req_ready = no hazard. Firing a jump moves the FSM to JWAIT.
  - JWAIT: req_ready = 0. When the jump slot is in DEPTH-1, the next state is RUN and redirect pulses.
- A stall cycle is any cycle with req_valid && !req_ready. It increments stall_cnt, which saturates at 0xFFFF.
- busy_mask and wb_* are combinational from the slots.

## Timing
- Reset (async, any time, including mid-jump): all slots empty, FSM = RUN, issue_valid = 0, bubble = 0, redirect = 0, stall_cnt = 0, busy_mask = 0, wb_valid = 0, wb_dest = 0. After release, req_ready = 1 in the first cycle.
- Issue latency: a request presented in cycle n with ready high gives issue_valid = 1 in cycle n+1.
- A writer issued in cycle n blocks a dependent instruction through cycle n+DEPTH. The dependent instruction issues in cycle n+DEPTH+1, so the minimum back-to-back dependency gap is DEPTH bubbles.
- Jump issued in cycle n: redirect = 1 in cycle n+DEPTH+1, and req_ready is high again in the same cycle.
- req_valid low gives bubble = 1 and no stall count.
- Exactly one of issue_valid and bubble is high every cycle after reset.

## Configuration
- ISSUE_STALL_CNT_EN
  - Defined: stall_cnt is implemented as above.
  - Undefined: no counter flops; stall_cnt is tied to 0.

## Structure
- Shared package (core_pkg): the CC encodings (AL/S/EQ/NE), the memory-op encoding, the PC register index 15, and the slot record typedef.
- One sub-module, sb_hazard_cmp: purely combinational. It compares one request against one slot and returns the hazard bit. It is instantiated DEPTH times and OR-reduced in the top module.

## Test plan
- Independent stream: back-to-back requests with dest 1, 2, 3, 4 and no src → ready is high every cycle, 4 issue_valid pulses, and stall_cnt = 0.
- RAW: request dest=2 wr, then src=2 src_en → exactly DEPTH (4) bubbles, the second issues in cycle n+5, and stall_cnt = 4.
- Flag: an S-setting add, then an EQ instruction → EQ held for 4 cycles; busy_mask shows bit dest set for 4 cycles.
- Jump: dest=15 wr issued in cycle 0 → ready low in cycles 1–4, redirect = 1 in cycle 5, busy_mask[15] = 1 in cycles 1–4.
- Memory: a store, then an unrelated load → load stalls 4 cycles; a load after a load issues immediately.
- Reset during JWAIT in cycle 2 → all outputs are 0 asynchronously, and after release the FSM is RUN with ready = 1 and no redirect pulse.
